// File: rtl/lpm_lookup_arbiter.sv
// Round-robin arbiter that shares one ARP/LPM lookup engine between several
// op_lut pipelines. One lookup is outstanding at a time; the result is held on
// a shared bus until the owning requester reads it.
module lpm_lookup_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned NUM_QUEUES = 8,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_vld,
  input  logic [32*NUM_REQ-1:0]   req_dst_ip,
  output logic [NUM_REQ-1:0]      req_rdy,
  output logic                    lkup_req,
  output logic [31:0]             lkup_dst_ip,
  input  logic                    lkup_rdy,
  input  logic                    lkup_done,
  input  logic [47:0]             lkup_next_hop_mac,
  input  logic [NUM_QUEUES-1:0]   lkup_output_port,
  input  logic                    lkup_arp_hit,
  input  logic                    lkup_lpm_hit,
  output logic [NUM_REQ-1:0]      rsp_vld,
  output logic [47:0]             rsp_next_hop_mac,
  output logic [NUM_QUEUES-1:0]   rsp_output_port,
  output logic                    rsp_arp_hit,
  output logic                    rsp_lpm_hit,
  input  logic [NUM_REQ-1:0]      rsp_rd,
  output logic                    lookup_timeout
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned TMR_W = 16;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE      = 4'b0001,
    ISSUE     = 4'b0010,
    WAIT_RESP = 4'b0100,
    HOLD_RESP = 4'b1000
  } state_t;

  typedef struct packed {
    logic [47:0]           mac;
    logic [NUM_QUEUES-1:0] port;
    logic                  arp_hit;
    logic                  lpm_hit;
  } result_t;

  state_t             state, state_nxt;
  logic               run;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic [IDX_W-1:0]   last_grant, last_grant_nxt;
  logic [TMR_W-1:0]   timer, timer_nxt;
  logic [NUM_REQ-1:0] req_rdy_nxt;
  logic               lkup_req_nxt;
  logic [31:0]        lkup_dst_ip_nxt;
  logic [NUM_REQ-1:0] rsp_vld_nxt;
  logic               lookup_timeout_nxt;
  result_t            rsp_q, rsp_nxt, eng_res;
  logic               gnt_found;
  logic [IDX_W-1:0]   gnt_idx;
  logic [IDX_W-1:0]   cand;
  logic [31:0]        req_ip [NUM_REQ];

  // Split the flat IP bus into one word per requester
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_ip
    assign req_ip[g] = req_dst_ip[32*g +: 32];
  end

  assign eng_res.mac     = lkup_next_hop_mac;
  assign eng_res.port    = lkup_output_port;
  assign eng_res.arp_hit = lkup_arp_hit;
  assign eng_res.lpm_hit = lkup_lpm_hit;

  assign rsp_next_hop_mac = rsp_q.mac;
  assign rsp_output_port  = rsp_q.port;
  assign rsp_arp_hit      = rsp_q.arp_hit;
  assign rsp_lpm_hit      = rsp_q.lpm_hit;

  // Gates the first grant until one clock after reset release
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) run <= 1'b0;
    else        run <= 1'b1;
  end

  // Round-robin pick: first active request after last_grant
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((32'(last_grant) + k) % NUM_REQ);
      if (!gnt_found && req_vld[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and next-output decode
  always_comb begin
    state_nxt          = state;
    idx_nxt            = idx;
    last_grant_nxt     = last_grant;
    timer_nxt          = timer;
    req_rdy_nxt        = '0;
    lkup_req_nxt       = 1'b0;
    lkup_dst_ip_nxt    = '0;
    rsp_vld_nxt        = rsp_vld;
    rsp_nxt            = rsp_q;
    lookup_timeout_nxt = 1'b0;
    case (state)
      IDLE: begin
        rsp_vld_nxt = '0;
        rsp_nxt     = '0;
        if (run && gnt_found) begin
          idx_nxt              = gnt_idx;
          req_rdy_nxt[gnt_idx] = 1'b1;
          lkup_req_nxt         = 1'b1;
          lkup_dst_ip_nxt      = req_ip[gnt_idx];
          state_nxt            = ISSUE;
        end
      end
      ISSUE: begin
        if (lkup_rdy) begin
          timer_nxt = '0;
          state_nxt = WAIT_RESP;
        end else begin
          lkup_req_nxt    = 1'b1;
          lkup_dst_ip_nxt = lkup_dst_ip;
        end
      end
      WAIT_RESP: begin
        timer_nxt = timer + TMR_W'(1);
        if (lkup_done) begin
          rsp_nxt          = eng_res;
          rsp_vld_nxt      = '0;
          rsp_vld_nxt[idx] = 1'b1;
          state_nxt        = HOLD_RESP;
        end else if (timer == TMR_LAST) begin
          rsp_nxt            = '0;
          rsp_vld_nxt        = '0;
          rsp_vld_nxt[idx]   = 1'b1;
          lookup_timeout_nxt = 1'b1;
          state_nxt          = HOLD_RESP;
        end
      end
      HOLD_RESP: begin
        if (rsp_rd[idx]) begin
          rsp_vld_nxt    = '0;
          rsp_nxt        = '0;
          last_grant_nxt = idx;
          state_nxt      = IDLE;
        end
      end
      default: begin
        rsp_vld_nxt = '0;
        rsp_nxt     = '0;
        state_nxt   = IDLE;
      end
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx            <= '0;
      last_grant     <= IDX_W'(NUM_REQ - 1);
      timer          <= '0;
      req_rdy        <= '0;
      lkup_req       <= 1'b0;
      lkup_dst_ip    <= '0;
      rsp_vld        <= '0;
      rsp_q          <= '0;
      lookup_timeout <= 1'b0;
    end else begin
      idx            <= idx_nxt;
      last_grant     <= last_grant_nxt;
      timer          <= timer_nxt;
      req_rdy        <= req_rdy_nxt;
      lkup_req       <= lkup_req_nxt;
      lkup_dst_ip    <= lkup_dst_ip_nxt;
      rsp_vld        <= rsp_vld_nxt;
      rsp_q          <= rsp_nxt;
      lookup_timeout <= lookup_timeout_nxt;
    end
  end

endmodule
